// File: rtl/prt_dprx_lnk_seq.sv
// ---------------------------------------------------------------------------
// prt_dprx_lnk_seq
//
// Link bring-up sequencer for the DP RX link path (link clock domain).
// Waits for CDR lock to be stable. It then enables the per-lane parsers on
// the active lanes and supervises scrambler lock. Timeout, lock loss and
// CDR loss all lead to a timed back-off and retry. Status and an interrupt
// are raised toward the system side.
//
// All interfaces are level signals; there is no valid/ready handshake.
// Inputs are sampled on every CLK_IN rising edge. Outputs are registered.
//
// Ports:
//   CLK_IN            link clock
//   RST_IN            asynchronous active-low reset
//   CTL_LNK_EN_IN     link enable from the control block
//   CTL_LANES_IN      active lanes (1 = 1 lane, 2 = 2 lanes, 3 = 4 lanes, 0 = none)
//   CDR_LOCK_IN       CDR lock from the PHY/training interface
//   SCRM_LOCK_IN      per-lane scrambler lock
//   PARS_LOCK_OUT     per-lane parser lock/enable
//   LNK_LOCK_OUT      all active lanes scrambler-locked
//   STA_STATE_OUT     current sequencer state (also the debug view of the FSM)
//   STA_FAIL_CNT_OUT  saturating timeout/loss event counter
//   IRQ_OUT           one-cycle pulse on the first back-off cycle
// ---------------------------------------------------------------------------
module prt_dprx_lnk_seq #(
    parameter int P_LANES       = 4,
    parameter int P_CDR_STABLE  = 256,
    parameter int P_SCRM_TMO    = 65536,
    parameter int P_LOSS_CYCLES = 16,
    parameter int P_BACKOFF     = 1024
) (
    input  logic               CLK_IN,
    input  logic               RST_IN,
    input  logic               CTL_LNK_EN_IN,
    input  logic [1:0]         CTL_LANES_IN,
    input  logic               CDR_LOCK_IN,
    input  logic [P_LANES-1:0] SCRM_LOCK_IN,
    output logic [P_LANES-1:0] PARS_LOCK_OUT,
    output logic               LNK_LOCK_OUT,
    output logic [2:0]         STA_STATE_OUT,
    output logic [7:0]         STA_FAIL_CNT_OUT,
    output logic               IRQ_OUT
);

    localparam int CDR_W  = (P_CDR_STABLE  > 1) ? $clog2(P_CDR_STABLE)  : 1;
    localparam int TMO_W  = (P_SCRM_TMO    > 1) ? $clog2(P_SCRM_TMO)    : 1;
    localparam int LOSS_W = (P_LOSS_CYCLES > 1) ? $clog2(P_LOSS_CYCLES) : 1;
    localparam int BO_W   = (P_BACKOFF     > 1) ? $clog2(P_BACKOFF)     : 1;

    // Terminal counts: the transition fires when the counter holds N-1 and
    // the qualifying condition is true, so each state lasts exactly N cycles.
    localparam logic [CDR_W-1:0]  CDR_LAST  = CDR_W'(P_CDR_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(P_SCRM_TMO - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(P_LOSS_CYCLES - 1);
    localparam logic [BO_W-1:0]   BO_LAST   = BO_W'(P_BACKOFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CDR  = 3'd1,
        ST_EN_PARS   = 3'd2,
        ST_WAIT_SCRM = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_BACKOFF   = 3'd5
    } state_t;

    state_t              state_q,    state_d;
    logic [CDR_W-1:0]    cdr_cnt_q,  cdr_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q,  tmo_cnt_d;
    logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic [BO_W-1:0]     bo_cnt_q,   bo_cnt_d;
    logic [1:0]          lanes_q,    lanes_d;
    logic [P_LANES-1:0]  mask_q,     mask_d;
    logic [P_LANES-1:0]  pars_q,     pars_d;
    logic                lnk_q,      lnk_d;
    logic                irq_q,      irq_d;
    logic [7:0]          fail_q,     fail_d;
    logic                en_q;
    logic                all_locked;
    logic                fail_evt;

    // Full 4-lane decode, truncated to the physical lane count.
    function automatic logic [P_LANES-1:0] lanes_to_mask(input logic [1:0] lanes);
        logic [3:0] full;
        case (lanes)
            2'd1:    full = 4'b0001;
            2'd2:    full = 4'b0011;
            2'd3:    full = 4'b1111;
            default: full = 4'b0000;
        endcase
        return full[P_LANES-1:0];
    endfunction

    // Unmasked lanes are don't-care for the aggregate lock.
    assign all_locked = ((SCRM_LOCK_IN & mask_q) == mask_q);

    always_comb begin
        state_d    = state_q;
        cdr_cnt_d  = '0;
        tmo_cnt_d  = '0;
        loss_cnt_d = '0;
        bo_cnt_d   = '0;
        lanes_d    = lanes_q;
        mask_d     = mask_q;
        pars_d     = pars_q;
        lnk_d      = lnk_q;
        irq_d      = 1'b0;
        fail_d     = fail_q;
        fail_evt   = 1'b0;

        if (!CTL_LNK_EN_IN) begin
            state_d = ST_IDLE;
            pars_d  = '0;
            lnk_d   = 1'b0;
        end else if ((state_q != ST_IDLE) && (CTL_LANES_IN != lanes_q)) begin
            // Lane reconfiguration on the fly: restart cleanly, not a failure.
            state_d = ST_IDLE;
            pars_d  = '0;
            lnk_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pars_d = '0;
                    lnk_d  = 1'b0;
                    if (CTL_LANES_IN != 2'd0) begin
                        state_d = ST_WAIT_CDR;
                        lanes_d = CTL_LANES_IN;
                        mask_d  = lanes_to_mask(CTL_LANES_IN);
                    end
                end
                ST_WAIT_CDR: begin
                    pars_d = '0;
                    lnk_d  = 1'b0;
                    if (CDR_LOCK_IN) begin
                        if (cdr_cnt_q == CDR_LAST) begin
                            state_d = ST_EN_PARS;
                        end else begin
                            cdr_cnt_d = cdr_cnt_q + CDR_W'(1);
                        end
                    end
                end
                ST_EN_PARS: begin
                    pars_d  = mask_q;
                    state_d = ST_WAIT_SCRM;
                end
                ST_WAIT_SCRM: begin
                    // Lock is tested before the timeout so a tie resolves to lock.
                    if (!CDR_LOCK_IN) begin
                        fail_evt = 1'b1;
                    end else if (all_locked) begin
                        state_d = ST_LOCKED;
                        lnk_d   = 1'b1;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        fail_evt = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!CDR_LOCK_IN) begin
                        fail_evt = 1'b1;
                    end else if (!all_locked) begin
                        if (loss_cnt_q == LOSS_LAST) begin
                            fail_evt = 1'b1;
                        end else begin
                            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                        end
                    end
                end
                ST_BACKOFF: begin
                    pars_d = '0;
                    lnk_d  = 1'b0;
                    if (bo_cnt_q == BO_LAST) begin
                        state_d = ST_WAIT_CDR;
                    end else begin
                        bo_cnt_d = bo_cnt_q + BO_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pars_d  = '0;
                    lnk_d   = 1'b0;
                end
            endcase

            if (fail_evt) begin
                state_d = ST_BACKOFF;
                pars_d  = '0;
                lnk_d   = 1'b0;
                irq_d   = 1'b1;
                fail_d  = (fail_q != 8'hFF) ? (fail_q + 8'd1) : fail_q;
            end
        end

        // A fresh link enable starts a new failure history. The FSM is in
        // IDLE on that cycle, so this never collides with an increment.
        if (CTL_LNK_EN_IN && !en_q) begin
            fail_d = 8'd0;
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q    <= ST_IDLE;
            cdr_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            loss_cnt_q <= '0;
            bo_cnt_q   <= '0;
            lanes_q    <= 2'd0;
            mask_q     <= '0;
            pars_q     <= '0;
            lnk_q      <= 1'b0;
            irq_q      <= 1'b0;
            fail_q     <= 8'd0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cdr_cnt_q  <= cdr_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            bo_cnt_q   <= bo_cnt_d;
            lanes_q    <= lanes_d;
            mask_q     <= mask_d;
            pars_q     <= pars_d;
            lnk_q      <= lnk_d;
            irq_q      <= irq_d;
            fail_q     <= fail_d;
            en_q       <= CTL_LNK_EN_IN;
        end
    end

    assign PARS_LOCK_OUT    = pars_q;
    assign LNK_LOCK_OUT     = lnk_q;
    assign STA_STATE_OUT    = state_q;
    assign STA_FAIL_CNT_OUT = fail_q;
    assign IRQ_OUT          = irq_q;

endmodule

// File: tb/tb_prt_dprx_lnk_seq.sv
// ---------------------------------------------------------------------------
// tb_prt_dprx_lnk_seq
//
// Directed bench for the link bring-up sequencer, built with shortened
// timing parameters. The driver issues stimulus and queues the state
// transitions it expects; each entry records the new state, the outputs,
// and how long the previous state lasted. The monitor pops one entry per
// observed state change.
// ---------------------------------------------------------------------------
module tb_prt_dprx_lnk_seq;

    localparam int P_LANES = 4;
    localparam int CDR_N   = 16;
    localparam int TMO_N   = 64;
    localparam int LOSS_N  = 16;
    localparam int BO_N    = 32;
    localparam int W       = 29;
    localparam logic [11:0] DC = 12'hFFF;  // dwell not checked

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [1:0]         lanes;
    logic               cdr;
    logic [P_LANES-1:0] scrm;
    logic [P_LANES-1:0] pars;
    logic               lnk;
    logic [2:0]         st;
    logic [7:0]         fail_cnt;
    logic               irq;

    int checks;
    int failures;
    int irq_cycles;
    int exp_irq;
    logic [W-1:0] exp_q[$];

    prt_dprx_lnk_seq #(
        .P_LANES      (P_LANES),
        .P_CDR_STABLE (CDR_N),
        .P_SCRM_TMO   (TMO_N),
        .P_LOSS_CYCLES(LOSS_N),
        .P_BACKOFF    (BO_N)
    ) dut (
        .CLK_IN          (clk),
        .RST_IN          (rst_n),
        .CTL_LNK_EN_IN   (en),
        .CTL_LANES_IN    (lanes),
        .CDR_LOCK_IN     (cdr),
        .SCRM_LOCK_IN    (scrm),
        .PARS_LOCK_OUT   (pars),
        .LNK_LOCK_OUT    (lnk),
        .STA_STATE_OUT   (st),
        .STA_FAIL_CNT_OUT(fail_cnt),
        .IRQ_OUT         (irq)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input logic [2:0] s, input logic [3:0] p,
                                        input logic l, input logic i,
                                        input logic [7:0] f, input logic [11:0] d);
        return {s, p, l, i, f, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (st !== s && n < budget);
        checks++;
        if (st !== s) begin
            failures++;
            $display("FAIL wait_state timeout got=%0d expected=%0d", st, s);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [2:0]   prev_st;
        int           cyc;
        int           last_cyc;
        int           tr;
        logic [W-1:0] e;
        logic [W-1:0] a;
        logic [11:0]  dw;
        prev_st    = 3'd0;
        cyc        = 0;
        last_cyc   = 0;
        tr         = 0;
        irq_cycles = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (irq === 1'b1) irq_cycles++;
            if (st !== prev_st) begin
                tr++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_transition #%0d got state=%0d from %0d", tr, st, prev_st);
                end else begin
                    e  = exp_q.pop_front();
                    dw = (e[11:0] == DC) ? DC : 12'(cyc - last_cyc);
                    a  = {st, pars, lnk, irq, fail_cnt, dw};
                    if (a !== e) begin
                        failures++;
                        $display("FAIL transition #%0d got st=%0d pars=%b lnk=%b irq=%b fcnt=%0d dwell=%0d expected st=%0d pars=%b lnk=%b irq=%b fcnt=%0d dwell=%0d",
                                 tr, a[28:26], a[25:22], a[21], a[20], a[19:12], a[11:0],
                                 e[28:26], e[25:22], e[21], e[20], e[19:12], e[11:0]);
                    end
                end
                prev_st  = st;
                last_cyc = cyc;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- driver ----------------
    initial begin
        checks   = 0;
        failures = 0;
        exp_irq  = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        lanes    = 2'd0;
        cdr      = 1'b0;
        scrm     = '0;
        #2 rst_n = 1'b0;
        tick(3);
        check_now("reset_outputs", {st, pars, lnk, irq, fail_cnt}, 17'd0);
        rst_n = 1'b1;
        tick(2);

        // Enabled with zero lanes: must stay in IDLE.
        en = 1'b1; lanes = 2'd0; cdr = 1'b1; scrm = 4'b0011;
        tick(5);
        check_now("idle_lanes0", {st, pars, lnk, irq, fail_cnt}, 17'd0);

        // Bring-up with 2 lanes.
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd0, DC));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd16));
        exp_q.push_back(mk(3'd3, 4'b0011, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd4, 4'b0011, 1'b1, 1'b0, 8'd0, 12'd1));
        lanes = 2'd2;
        wait_state(3'd4, 100);

        // Lane 1 drops 15 cycles (tolerated), then 16 cycles (lock lost).
        scrm = 4'b0001; tick(15); scrm = 4'b0011; tick(5);
        check_now("loss15_locked", {14'd0, st}, {14'd0, 3'd4});
        exp_q.push_back(mk(3'd5, 4'b0000, 1'b0, 1'b1, 8'd1, 12'd36));
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd1, 12'd32));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd1, 12'd16));
        exp_q.push_back(mk(3'd3, 4'b0011, 1'b0, 1'b0, 8'd1, 12'd1));
        exp_q.push_back(mk(3'd4, 4'b0011, 1'b1, 1'b0, 8'd1, 12'd1));
        exp_irq++;
        scrm = 4'b0001; tick(16); scrm = 4'b0011;
        wait_state(3'd4, 200);

        // Link enable toggle (clears fail count), then CDR glitch at count 10.
        exp_q.push_back(mk(3'd0, 4'b0000, 1'b0, 1'b0, 8'd1, 12'd1));
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd27));
        exp_q.push_back(mk(3'd3, 4'b0011, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd4, 4'b0011, 1'b1, 1'b0, 8'd0, 12'd1));
        en = 1'b0; tick(1); en = 1'b1;
        wait_state(3'd1, 10);
        tick(10); cdr = 1'b0; tick(1); cdr = 1'b1;
        wait_state(3'd4, 100);

        // Lane count change 2 -> 1 while locked: restart with mask 0001.
        exp_q.push_back(mk(3'd0, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd16));
        exp_q.push_back(mk(3'd3, 4'b0001, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd4, 4'b0001, 1'b1, 1'b0, 8'd0, 12'd1));
        lanes = 2'd1;
        wait_state(3'd4, 100);

        // Four lanes, lane 3 never locks: timeout, back-off, retry.
        exp_q.push_back(mk(3'd0, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd0, 12'd16));
        exp_q.push_back(mk(3'd3, 4'b1111, 1'b0, 1'b0, 8'd0, 12'd1));
        exp_q.push_back(mk(3'd5, 4'b0000, 1'b0, 1'b1, 8'd1, 12'd64));
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd1, 12'd32));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd1, 12'd16));
        exp_q.push_back(mk(3'd3, 4'b1111, 1'b0, 1'b0, 8'd1, 12'd1));
        exp_irq++;
        lanes = 2'd3; scrm = 4'b0111;
        wait_state(3'd5, 200);
        wait_state(3'd3, 200);

        // Lane 3 locks on the very cycle the timeout would fire: lock wins.
        exp_q.push_back(mk(3'd4, 4'b1111, 1'b1, 1'b0, 8'd1, 12'd64));
        tick(63); scrm = 4'b1111;
        wait_state(3'd4, 10);

        // CDR loss while locked: immediate back-off.
        exp_q.push_back(mk(3'd5, 4'b0000, 1'b0, 1'b1, 8'd2, 12'd1));
        exp_q.push_back(mk(3'd1, 4'b0000, 1'b0, 1'b0, 8'd2, 12'd32));
        exp_q.push_back(mk(3'd2, 4'b0000, 1'b0, 1'b0, 8'd2, 12'd16));
        exp_q.push_back(mk(3'd3, 4'b1111, 1'b0, 1'b0, 8'd2, 12'd1));
        exp_irq++;
        cdr = 1'b0; scrm = 4'b0111; tick(1); cdr = 1'b1;
        wait_state(3'd3, 200);

        // Asynchronous reset in the middle of WAIT_SCRM.
        tick(10);
        exp_q.push_back(mk(3'd0, 4'b0000, 1'b0, 1'b0, 8'd0, DC));
        rst_n = 1'b0;
        #1;
        check_now("async_reset", {st, pars, lnk, irq, fail_cnt}, 17'd0);
        en = 1'b0; lanes = 2'd0;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        check_now("irq_pulse_cycles", 17'(irq_cycles), 17'(exp_irq));
        check_now("queue_drained", 17'(exp_q.size()), 17'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
